// File: rtl/lfsr_bit_receiver_if.sv
// Handshake/bus bundle for lfsr_bit_receiver.
//   master : line/key/ready driver side (drives enable, xored_in, data_in, data_in1, out_ready)
//   slave  : receiver side (drives user_out, data_byte, byte_valid, locked, overflow)
// Signals:
//   enable     bit strobe, one serial bit consumed per enabled clock edge
//   xored_in   scrambled serial bit from the line
//   data_in    first key pattern, indexed LSB-first by the key counter
//   data_in1   second key pattern, indexed LSB-first by the key counter
//   out_ready  downstream accepts data_byte while byte_valid is high
//   user_out   registered descrambled bit
//   data_byte  assembled byte, first received bit in bit 0
//   byte_valid data_byte holds an unaccepted byte
//   locked     receiver is frame-aligned
//   overflow   sticky: a completed byte was dropped
interface lfsr_bit_receiver_if;
  logic       enable;
  logic       xored_in;
  logic [7:0] data_in;
  logic [7:0] data_in1;
  logic       out_ready;
  logic       user_out;
  logic [7:0] data_byte;
  logic       byte_valid;
  logic       locked;
  logic       overflow;

  modport master (
    output enable, xored_in, data_in, data_in1, out_ready,
    input  user_out, data_byte, byte_valid, locked, overflow
  );

  modport slave (
    input  enable, xored_in, data_in, data_in1, out_ready,
    output user_out, data_byte, byte_valid, locked, overflow
  );
endinterface

// File: rtl/lfsr_bit_receiver.sv
// Serial descrambling receiver. Each enabled bit is XORed with two key patterns indexed by a
// free-running 3-bit key counter, then assembled LSB-first into bytes handed off through a
// valid/ready output with a sticky overflow flag for dropped bytes.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-low reset
//   bus    lfsr_bit_receiver_if.slave (see interface file for signal list)
// Parameter:
//   SYNC_WORD  frame-alignment byte matched in the descrambled stream
// Build option:
//   RX_SYNC_EN  when defined, the receiver starts in HUNT and searches the descrambled stream
//               for SYNC_WORD before assembling bytes. When undefined, there is no hunt logic,
//               the receiver is always in LOCK and locked is tied high.
module lfsr_bit_receiver #(
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input logic                clk,
  input logic                reset,
  lfsr_bit_receiver_if.slave bus
);

  typedef enum logic {StHunt, StLock} state_e;

  logic [2:0] kc;
  logic [2:0] bc;
  logic [6:0] asm_bits;   // first seven bits of the byte in flight, newest at bit 6
  logic       user_out;
  logic [7:0] data_byte;
  logic       byte_valid;
  logic       overflow;
  logic       d;
  logic       accept;
  logic [7:0] done_byte;
  state_e     state;

  assign d         = bus.xored_in ^ bus.data_in[kc] ^ bus.data_in1[kc];
  assign accept    = byte_valid & bus.out_ready;
  // When bc is 7 the shift register holds bits 0..6 in order, d supplies bit 7.
  assign done_byte = {d, asm_bits};

`ifdef RX_SYNC_EN
  logic [7:0] window;
  logic [7:0] window_next;
  assign window_next = {d, window[7:1]};
`else
  assign state = StLock;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kc         <= 3'd0;
      bc         <= 3'd0;
      asm_bits   <= 7'd0;
      user_out   <= 1'b0;
      data_byte  <= 8'd0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef RX_SYNC_EN
      state      <= StHunt;
      window     <= 8'd0;
`endif
    end else begin
      // Acceptance does not depend on enable; a completion below may re-set byte_valid.
      if (accept) begin
        byte_valid <= 1'b0;
      end
      if (bus.enable) begin
        kc       <= kc + 3'd1;
        user_out <= d;
        if (state == StLock) begin
          bc       <= bc + 3'd1;
          asm_bits <= {d, asm_bits[6:1]};
          if (bc == 3'd7) begin
            if (!byte_valid || bus.out_ready) begin
              data_byte  <= done_byte;
              byte_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
`ifdef RX_SYNC_EN
        else begin
          window <= window_next;
          if (window_next == SYNC_WORD) begin
            state <= StLock;
            bc    <= 3'd0;
          end
        end
`endif
      end
    end
  end

  assign bus.user_out   = user_out;
  assign bus.data_byte  = data_byte;
  assign bus.byte_valid = byte_valid;
  assign bus.overflow   = overflow;
  assign bus.locked     = (state == StLock);

endmodule

// File: tb/tb_lfsr_bit_receiver.sv
module tb_lfsr_bit_receiver;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lfsr_bit_receiver_if bus ();

  lfsr_bit_receiver #(
    .SYNC_WORD(8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RX_SYNC_EN
  localparam logic LockAfterReset = 1'b0;
`else
  localparam logic LockAfterReset = 1'b1;
`endif

  task automatic apply_reset();
    bus.enable    = 1'b0;
    bus.xored_in  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    bus.enable   = 1'b1;
    bus.xored_in = b;
    @(posedge clk);
    #1;
    bus.enable   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.data_in   = 8'h00;
    bus.data_in1  = 8'h00;
    bus.out_ready = 1'b0;
    apply_reset();
    checks++;
    if (bus.data_byte !== 8'h00) begin
      errors++; $display("FAIL reset_data_byte: got %h want 00", bus.data_byte);
    end
    checks++;
    if (bus.byte_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.user_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b ovf=%b user_out=%b want 0 0 0",
               bus.byte_valid, bus.overflow, bus.user_out);
    end
    checks++;
    if (bus.locked !== LockAfterReset) begin
      errors++; $display("FAIL reset_locked: got %b want %b", bus.locked, LockAfterReset);
    end
  endtask

`ifndef RX_SYNC_EN
  // Plain serial byte with zero keys, user_out follows every bit.
  task automatic test_basic();
    logic [7:0] v;
    v = 8'h3C;
    bus.data_in = 8'h00; bus.data_in1 = 8'h00; bus.out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      checks++;
      if (bus.user_out !== v[i]) begin
        errors++; $display("FAIL basic_user_out[%0d]: got %b want %b", i, bus.user_out, v[i]);
      end
      if (i < 7) begin
        checks++;
        if (bus.byte_valid !== 1'b0) begin
          errors++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, bus.byte_valid);
        end
      end
    end
    checks++;
    if (bus.data_byte !== 8'h3C || bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_byte: got %h/%b want 3c/1", bus.data_byte, bus.byte_valid);
    end
    idle_cycle();
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++; $display("FAIL basic_accept: valid=%b want 0", bus.byte_valid);
    end
  endtask

  task automatic test_keys();
    // Complementary keys invert every bit.
    bus.data_in = 8'hF0; bus.data_in1 = 8'h0F; bus.out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0);
      checks++;
      if (bus.user_out !== 1'b1) begin
        errors++; $display("FAIL keys_user_out[%0d]: got %b want 1", i, bus.user_out);
      end
    end
    checks++;
    if (bus.data_byte !== 8'hFF) begin
      errors++; $display("FAIL keys_byte: got %h want ff", bus.data_byte);
    end
    // Asymmetric keys: 0x0F ^ 0x35 ^ 0xC0 = 0xFA.
    bus.data_in = 8'h35; bus.data_in1 = 8'hC0;
    apply_reset();
    send_byte(8'h0F);
    checks++;
    if (bus.data_byte !== 8'hFA) begin
      errors++; $display("FAIL keys_mixed_byte: got %h want fa", bus.data_byte);
    end
  endtask

  task automatic test_idle_hold();
    // Key 0x35, serial 0xA0 with a pause mid-byte: 0xA0 ^ 0x35 = 0x95.
    bus.data_in = 8'h35; bus.data_in1 = 8'h00; bus.out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    // Last enabled bit was 0 ^ key[3] = 0.
    for (int i = 0; i < 3; i++) begin
      bus.xored_in = ~bus.xored_in;
      idle_cycle();
      checks++;
      if (bus.user_out !== 1'b0 || bus.byte_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: user_out=%b valid=%b want 0 0",
                 i, bus.user_out, bus.byte_valid);
      end
    end
    for (int i = 4; i < 8; i++) send_bit((i == 5 || i == 7) ? 1'b1 : 1'b0);
    checks++;
    if (bus.data_byte !== 8'h95 || bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL idle_byte: got %h/%b want 95/1", bus.data_byte, bus.byte_valid);
    end
  endtask
`else
  task automatic test_sync();
    bus.data_in = 8'h00; bus.data_in1 = 8'h00; bus.out_ready = 1'b1;
    apply_reset();
    send_byte(8'hFF);
    checks++;
    if (bus.locked !== 1'b0 || bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL sync_preamble: locked=%b valid=%b want 0 0", bus.locked, bus.byte_valid);
    end
    for (int i = 0; i < 7; i++) send_bit((8'hA5 >> i) & 8'h01 ? 1'b1 : 1'b0);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL sync_early_lock: got %b want 0", bus.locked);
    end
    send_bit(1'b1);
    checks++;
    if (bus.locked !== 1'b1 || bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL sync_lock: locked=%b valid=%b want 1 0", bus.locked, bus.byte_valid);
    end
    send_byte(8'h5A);
    checks++;
    if (bus.data_byte !== 8'h5A || bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL sync_first_byte: got %h/%b want 5a/1", bus.data_byte, bus.byte_valid);
    end
  endtask

  task automatic lock_up();
    send_byte(8'hA5);
  endtask
`endif

  task automatic test_overflow();
    bus.data_in = 8'h00; bus.data_in1 = 8'h00; bus.out_ready = 1'b0;
    apply_reset();
`ifdef RX_SYNC_EN
    lock_up();
`endif
    send_byte(8'h11);
    checks++;
    if (bus.data_byte !== 8'h11 || bus.byte_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: got %h/%b/%b want 11/1/0",
               bus.data_byte, bus.byte_valid, bus.overflow);
    end
    send_byte(8'h22);
    checks++;
    if (bus.data_byte !== 8'h11 || bus.byte_valid !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got %h/%b/%b want 11/1/1",
               bus.data_byte, bus.byte_valid, bus.overflow);
    end
    idle_cycle();
    checks++;
    if (bus.data_byte !== 8'h11 || bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold: got %h/%b want 11/1", bus.data_byte, bus.byte_valid);
    end
    bus.out_ready = 1'b1;
    idle_cycle();
    checks++;
    if (bus.byte_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_release: valid=%b ovf=%b want 0 1", bus.byte_valid, bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    v = 8'h77;
    bus.data_in = 8'h00; bus.data_in1 = 8'h00; bus.out_ready = 1'b0;
    apply_reset();
`ifdef RX_SYNC_EN
    lock_up();
`endif
    send_byte(8'h55);
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    checks++;
    if (bus.data_byte !== 8'h55 || bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pending: got %h/%b want 55/1", bus.data_byte, bus.byte_valid);
    end
    bus.out_ready = 1'b1;
    send_bit(v[7]);
    checks++;
    if (bus.data_byte !== 8'h77 || bus.byte_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_same_edge: got %h/%b/%b want 77/1/0",
               bus.data_byte, bus.byte_valid, bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    bus.data_in = 8'h35; bus.data_in1 = 8'h00; bus.out_ready = 1'b0;
    apply_reset();
`ifdef RX_SYNC_EN
    send_byte(8'hA5 ^ 8'h35);
`endif
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    checks++;
    if (bus.overflow !== 1'b1 || bus.user_out !== 1'b1 || bus.data_byte !== 8'h35) begin
      errors++;
      $display("FAIL mid_before: ovf=%b user_out=%b byte=%h want 1 1 35",
               bus.overflow, bus.user_out, bus.data_byte);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.data_byte !== 8'h00 || bus.byte_valid !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.user_out !== 1'b0 || bus.locked !== LockAfterReset) begin
      errors++;
      $display("FAIL mid_async_clear: byte=%h valid=%b ovf=%b user_out=%b locked=%b",
               bus.data_byte, bus.byte_valid, bus.overflow, bus.user_out, bus.locked);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
`ifdef RX_SYNC_EN
    send_byte(8'hA5 ^ 8'h35);
`endif
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++; $display("FAIL mid_partial: valid=%b want 0", bus.byte_valid);
    end
    send_bit(1'b0);
    checks++;
    if (bus.data_byte !== 8'h35 || bus.byte_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_rekey: got %h/%b/%b want 35/1/0",
               bus.data_byte, bus.byte_valid, bus.overflow);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.xored_in  = 1'b0;
    bus.data_in   = 8'h00;
    bus.data_in1  = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
`ifndef RX_SYNC_EN
    test_basic();
    test_keys();
    test_idle_hold();
`else
    test_sync();
`endif
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_bit_receiver.md
LFSR_BIT_RECEIVER -- requirements
Module: lfsr_bit_receiver

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5, frame-alignment byte matched in the descrambled stream (used only with RX_SYNC_EN).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  bit strobe; one serial bit is consumed per clk edge with enable=1.
REQ-005 xored_in  input  1  scrambled serial bit from the line.
REQ-006 data_in  input  8  first key pattern, indexed LSB-first by the key counter.
REQ-007 data_in1  input  8  second key pattern, indexed LSB-first by the key counter.
REQ-008 out_ready  input  1  downstream accepts data_byte when high with byte_valid.
REQ-009 user_out  output  1  registered descrambled bit.
REQ-010 data_byte  output  8  assembled byte, LSB first received.
REQ-011 byte_valid  output  1  data_byte holds an unaccepted byte.
REQ-012 locked  output  1  receiver is frame-aligned.
REQ-013 overflow  output  1  sticky flag: a completed byte was dropped.

Function
REQ-014 Key counter kc (3 bits) shall increment modulo 8 on every enabled cycle from reset, independent of state; wraps 7->0.
REQ-015 Descrambled bit d = xored_in ^ data_in[kc] ^ data_in1[kc]; user_out shall register d one cycle after the enabled sample.
REQ-016 States: HUNT and LOCK; with enable=0 no state, counter, or shift register shall change.
REQ-017 In HUNT, d shall shift into an 8-bit window at bit 7 (window shifts right); when the updated window equals SYNC_WORD, the state shall go to LOCK on that edge, with bit counter bc=0; the sync byte shall not be output.
REQ-018 In LOCK, d shall be written to assembly register bit bc, and bc shall increment modulo 8; when bc=7, the completed byte shall transfer to data_byte and byte_valid shall assert on the same edge.
REQ-019 A byte is accepted on an edge where byte_valid=1 and out_ready=1; byte_valid shall then clear unless a new byte completes on that edge.
REQ-020 Simultaneous accept and completion: the new byte shall load and byte_valid shall stay 1; overflow unchanged.
REQ-021 Completion while byte_valid=1 and out_ready=0: the new byte shall be dropped, data_byte held, and overflow set (sticky until reset).
REQ-022 locked shall be 1 exactly while in LOCK; LOCK is held until reset.
REQ-023 data_byte and byte_valid shall not change while byte_valid=1 and out_ready=0, except via reset.

Reset
REQ-024 reset=0 shall asynchronously clear kc, bc, the window, the assembly register, user_out, data_byte, byte_valid, and overflow to 0, and set the state to HUNT (or LOCK per REQ-026).
REQ-025 Reset asserted mid-byte shall discard the partial byte; after release, key and bit counting shall restart at index 0.

Configuration
REQ-026 With RX_SYNC_EN defined: HUNT/LOCK behaviour per REQ-017, and locked=0 after reset. Without it: no HUNT logic or window; the state after reset is LOCK, locked is tied to 1, and SYNC_WORD is unused.

Verification
REQ-027 No RX_SYNC_EN, data_in=data_in1=8'h00, serial 0x3C LSB-first on 8 enabled cycles, out_ready=1 -> data_byte=8'h3C, byte_valid=1 for one cycle.
REQ-028 No RX_SYNC_EN, data_in=8'hF0, data_in1=8'h0F, serial 8'h00 -> user_out all 1s, data_byte=8'hFF.
REQ-029 RX_SYNC_EN, keys 8'h00, serial 0xFF, then 0xA5 and 0x5A -> locked rises on the last bit of 0xA5; the first output byte is 8'h5A.
REQ-030 out_ready=0, two bytes 0x11 then 0x22 -> data_byte stays 8'h11, overflow=1; then out_ready=1 -> byte_valid clears and overflow stays 1.
REQ-031 Accept on the same edge as the 8th bit of 0x77 -> data_byte=8'h77, byte_valid stays 1, overflow=0.
REQ-032 reset pulsed after 4 bits of a byte -> all outputs 0; the next 8 bits form a complete byte keyed from kc=0.
